// File: rtl/cpu_key_in_if.sv
// Avalon-MM slave bus bundle for the key input PIO.
// The CPU side drives address/strobes; the PIO returns read data and a level IRQ.
interface cpu_key_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface

// File: rtl/cpu_key_in.sv
// Avalon-MM input PIO for push-buttons/keys.
// Each pin is synchronised, debounced and edge-detected. Detected edges latch into a
// sticky write-1-to-clear capture register, and a level IRQ is raised for unmasked captures.
module cpu_key_in #(
    parameter int unsigned       WIDTH           = 4,
    parameter int unsigned       DEBOUNCE_CYCLES = 500000,
    parameter int unsigned       EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE     = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    cpu_key_in_if.slave      bus,
    input  logic [WIDTH-1:0] in_port
);

    localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] edge_ev;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] cap_clr;
    logic             wr_en;
    logic             unused_wdata;

    // Only the low WIDTH bits of writedata carry meaning.
    assign unused_wdata = &{1'b0, bus.writedata};

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= RESET_VALUE;
            s2 <= RESET_VALUE;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end

    // Per-bit debounce: accept a new level only after it has held DEBOUNCE_CYCLES clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= RESET_VALUE;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Delayed copy of the debounced state; resets to the same value so reset is edge-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d <= RESET_VALUE;
        end else begin
            stable_d <= stable;
        end
    end

    // Select the edge polarity that counts as an event.
    always_comb begin
        edge_ev = '0;
        case (EDGE_TYPE)
            0:       edge_ev = stable & ~stable_d;
            1:       edge_ev = ~stable & stable_d;
            default: edge_ev = stable ^ stable_d;
        endcase
    end

    // Decode bus writes into the capture-clear vector.
    always_comb begin
        wr_en   = bus.chipselect & ~bus.write_n;
        cap_clr = '0;
        if (wr_en && bus.address == 2'd3) begin
            cap_clr = bus.writedata[WIDTH-1:0];
        end
    end

    // Sticky edge capture; a same-cycle event overrides a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecapture <= '0;
        end else begin
            edgecapture <= (edgecapture & ~cap_clr) | edge_ev;
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
        end else if (wr_en && bus.address == 2'd2) begin
            irqmask <= bus.writedata[WIDTH-1:0];
        end
    end

    // Zero-wait-state read mux and level interrupt, both straight from registers.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata[WIDTH-1:0] = stable;
            2'd2:    bus.readdata[WIDTH-1:0] = irqmask;
            2'd3:    bus.readdata[WIDTH-1:0] = edgecapture;
            default: bus.readdata = '0;
        endcase
        bus.irq = |(edgecapture & irqmask);
    end

endmodule

// File: tb/tb_cpu_key_in.sv
// Bench for cpu_key_in: directed key scenarios plus randomised pin/bus traffic.
// Expected read data and irq are queued at issue time and compared by a separate monitor.
module tb_cpu_key_in;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] in_port;
  bit         done = 1'b0;

  cpu_key_in_if bus ();

  cpu_key_in #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(DC),
    .EDGE_TYPE(1),
    .RESET_VALUE(4'hF)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave),
    .in_port(in_port)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Pins reach the debouncer two samples late; a key is accepted once its delayed
  // level has disagreed with the accepted level for DC consecutive clocks.
  logic [3:0] pin_hist [2];
  logic [3:0] m_stable, m_prev, m_mask, m_cap;
  int         run [4];

  always @(posedge clk or negedge reset_n) begin
    logic [3:0] fell;
    logic [3:0] clr;
    logic [3:0] seen;
    if (!reset_n) begin
      pin_hist[0] = 4'hF;
      pin_hist[1] = 4'hF;
      m_stable    = 4'hF;
      m_prev      = 4'hF;
      m_mask      = 4'h0;
      m_cap       = 4'h0;
      for (int i = 0; i < 4; i++) run[i] = 0;
    end else begin
      fell = m_prev & ~m_stable;
      clr  = (bus.chipselect && !bus.write_n && bus.address == 2'd3) ? bus.writedata[3:0] : 4'h0;
      m_cap = (m_cap & ~clr) | fell;
      if (bus.chipselect && !bus.write_n && bus.address == 2'd2) m_mask = bus.writedata[3:0];
      m_prev = m_stable;
      seen   = pin_hist[1];
      for (int i = 0; i < 4; i++) begin
        if (seen[i] == m_stable[i]) begin
          run[i] = 0;
        end else begin
          run[i] = run[i] + 1;
          if (run[i] == DC) begin
            m_stable[i] = seen[i];
            run[i]      = 0;
          end
        end
      end
      pin_hist[1] = pin_hist[0];
      pin_hist[0] = in_port;
    end
  end

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'h0, m_stable};
      2'd2:    return {28'h0, m_mask};
      2'd3:    return {28'h0, m_cap};
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_irq;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   checks   = 0;
  int   failures = 0;

  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] got;
    while (q.size() > 0) begin
      c   = q.pop_front();
      got = c.is_irq ? {31'h0, bus.irq} : bus.readdata;
      checks++;
      if (got !== c.exp) begin
        failures++;
        $display("FAIL %s: got=%h expected=%h at t=%0t", c.name, got, c.exp, $time);
      end
    end
  end

  initial begin
    #2000000;
    if (!done) begin
      failures++;
      $display("FAIL timeout: stimulus did not complete by t=%0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic push_pair(input logic [31:0] exp_rd, input bit exp_irq, input string nm);
    chk_t c;
    c.is_irq = 1'b0; c.exp = exp_rd;           c.name = nm;           q.push_back(c);
    c.is_irq = 1'b1; c.exp = {31'h0, exp_irq}; c.name = {nm, "_irq"}; q.push_back(c);
  endtask

  // Read with spec-derived constant expectations.
  task automatic chk(input logic [1:0] a, input logic [31:0] exp_rd, input bit exp_irq, input string nm);
    @(posedge clk); #1;
    bus.address    = a;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    push_pair(exp_rd, exp_irq, nm);
  endtask

  // Read with expectations from the reference model.
  task automatic chk_model(input logic [1:0] a, input string nm);
    @(posedge clk); #1;
    bus.address    = a;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    push_pair(model_read(a), |(m_cap & m_mask), nm);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    in_port        = 4'h0;
    reset_n        = 1'b0;

    // Reset state while held in reset with pins low.
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.readdata !== 32'hF || bus.irq !== 1'b0) begin
      failures++;
      $display("FAIL rst_direct: readdata=%h irq=%b expected=0000000f/0 at t=%0t",
               bus.readdata, bus.irq, $time);
    end
    chk(2'd0, 32'hF, 1'b0, "rst_data");
    chk(2'd2, 32'h0, 1'b0, "rst_mask");
    chk(2'd3, 32'h0, 1'b0, "rst_cap");
    chk(2'd1, 32'h0, 1'b0, "rst_resv");
    @(posedge clk); #1;
    in_port = 4'hF;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);

    // Clean press of key0: accepted exactly 2+DC clocks after the pin change.
    @(posedge clk); #1;
    in_port[0] = 1'b0;
    repeat (4) @(posedge clk);
    chk(2'd0, 32'hF, 1'b0, "press_early");
    chk(2'd0, 32'hE, 1'b0, "press_data");
    chk(2'd3, 32'h1, 1'b0, "press_cap");
    in_port[0] = 1'b1;
    repeat (10) @(posedge clk);
    chk(2'd3, 32'h1, 1'b0, "release_keeps_cap");
    chk(2'd0, 32'hF, 1'b0, "release_data");
    wr(2'd3, 32'hF);
    chk(2'd3, 32'h0, 1'b0, "w1c_clear");

    // Glitch of 3 samples on key1: never accepted.
    @(posedge clk); #1;
    in_port[1] = 1'b0;
    repeat (3) @(posedge clk); #1;
    in_port[1] = 1'b1;
    for (int i = 0; i < 6; i++) chk(2'd0, 32'hF, 1'b0, "glitch_data");
    chk(2'd3, 32'h0, 1'b0, "glitch_cap");

    // Pulse of exactly DC samples on key1: accepted, then released.
    @(posedge clk); #1;
    in_port[1] = 1'b0;
    repeat (4) @(posedge clk); #1;
    in_port[1] = 1'b1;
    for (int i = 0; i < 12; i++) chk_model(2'(i % 4), "pulse_dc");
    chk(2'd3, 32'h2, 1'b0, "pulse_dc_cap");
    wr(2'd3, 32'hF);

    // IRQ: unmasked capture raises irq, write-1-to-clear drops it.
    wr(2'd2, 32'h1);
    chk(2'd2, 32'h1, 1'b0, "mask_rd");
    @(posedge clk); #1;
    in_port[0] = 1'b0;
    repeat (5) @(posedge clk);
    chk(2'd0, 32'hE, 1'b0, "irq_press_data");
    chk(2'd3, 32'h1, 1'b1, "irq_set");
    wr(2'd3, 32'h1);
    chk(2'd3, 32'h0, 1'b0, "irq_cleared");
    in_port[0] = 1'b1;
    repeat (10) @(posedge clk);
    chk(2'd3, 32'h0, 1'b0, "irq_release");

    // Clear write in the same cycle as key2's edge event: set wins.
    @(posedge clk); #1;
    in_port[2] = 1'b0;
    repeat (5) @(posedge clk);
    wr(2'd3, 32'h4);
    chk(2'd3, 32'h4, 1'b0, "collision_cap");
    in_port[2] = 1'b1;
    repeat (10) @(posedge clk);
    wr(2'd3, 32'hF);
    chk(2'd3, 32'h0, 1'b0, "pre_rst_cap");

    // Reset in the middle of key3's debounce.
    @(posedge clk); #1;
    in_port[3] = 1'b0;
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b0;
    chk(2'd0, 32'hF, 1'b0, "midrst_data");
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    chk(2'd0, 32'hF, 1'b0, "midrst_early");
    chk(2'd0, 32'h7, 1'b0, "midrst_data_after");
    chk(2'd3, 32'h8, 1'b0, "midrst_cap");
    chk(2'd2, 32'h0, 1'b0, "midrst_mask");

    // Randomised pin and bus traffic against the model.
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      if ($urandom_range(5) == 0) begin
        int idx;
        idx = int'($urandom_range(3));
        in_port[idx] = ~in_port[idx];
      end
      bus.address    = 2'($urandom);
      bus.chipselect = 1'($urandom);
      bus.write_n    = ($urandom_range(3) != 0);
      bus.writedata  = $urandom;
      push_pair(model_read(bus.address), |(m_cap & m_mask), "random");
    end

    @(posedge clk); #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    @(negedge clk); #1;
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
